// File: rtl/ov7670_sccb_config_if.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_config_if
//   SCCB bus bundle between the OV7670 setup sequencer and the camera pins.
//   sioc    : SCCB clock, push-pull, driven by the master
//   siod_oe : 1 = master pulls SIOD low, 0 = released (external pull-up)
//   siod_in : sampled SIOD line returned to the master (ACK checking only)
//   master modport: sequencer side; slave modport: pad / camera side.
// ---------------------------------------------------------------------------
interface ov7670_sccb_config_if;
  logic sioc;
  logic siod_oe;
  logic siod_in;

  modport master (
    output sioc,
    output siod_oe,
    input  siod_in
  );

  modport slave (
    input  sioc,
    input  siod_oe,
    output siod_in
  );
endinterface

// File: rtl/ov7670_sccb_config.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_config
//   Walks an external register table and writes each entry to the OV7670
//   over SCCB as one 3-phase write {DEV_ADDR, reg, val}. Table entry
//   16'hFFF0 inserts a DELAY_MS pause, 16'hFFFF ends the table. Index 255 is
//   the last entry processed even without an end marker.
//
//   Ports:
//     clk        system clock
//     reset      asynchronous, active-low reset
//     start      one-cycle start pulse (accepted in IDLE/DONE only)
//     rom_addr   registered table index
//     rom_data   table entry {reg, val}, valid one cycle after rom_addr
//     sccb       SCCB bus (master modport): sioc, siod_oe, siod_in
//     busy       high from accepted start until done
//     setup_done level, high after table end until next accepted start
//     err        sticky NACK failure flag (constant 0 without ACK checking)
//
//   Optional feature: define SCCB_ACK_CHECK_EN to sample the 9th bit of each
//   byte, retry an entry up to 3 times on NACK, then flag err and finish.
// ---------------------------------------------------------------------------
module ov7670_sccb_config #(
  parameter int unsigned CLK_FREQ_HZ  = 25000000,
  parameter int unsigned SCCB_FREQ_HZ = 100000,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter int unsigned DELAY_MS     = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic [7:0]                  rom_addr,
  input  logic [15:0]                 rom_data,
  ov7670_sccb_config_if.master        sccb,
  output logic                        busy,
  output logic                        setup_done,
  output logic                        err
);

  localparam int unsigned QDIV      = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int unsigned QW        = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int unsigned DELAY_CYC = CLK_FREQ_HZ / 1000 * DELAY_MS;
  localparam int unsigned DW        = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
  localparam int unsigned DLY_LAST  = (DELAY_CYC > 0) ? DELAY_CYC - 1 : 0;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    START,
    BITS,
    STOP,
    GAP,
    DELAY,
    DONE
  } state_t;

  state_t          state;
  logic [QW-1:0]   qcnt;     // cycles within the current quarter
  logic [1:0]      q;        // quarter index within the current phase/bit
  logic [4:0]      bitcnt;   // 0..26, bit being shifted out
  logic [26:0]     shreg;    // {DEV_ADDR,1,reg,1,val,1}, MSB first
  logic [DW-1:0]   dcnt;
  logic            qtick;

  assign qtick = (qcnt == QW'(QDIV - 1));

`ifdef SCCB_ACK_CHECK_EN
  logic       nack;
  logic [1:0] retries;
  logic       ack_slot;

  // 9th bit of each byte: bit indices 8, 17, 26
  assign ack_slot = (bitcnt == 5'd8) || (bitcnt == 5'd17) || (bitcnt == 5'd26);
`else
  logic unused_siod_in;

  assign unused_siod_in = sccb.siod_in;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rom_addr     <= '0;
      busy         <= 1'b0;
      setup_done   <= 1'b0;
      sccb.sioc    <= 1'b1;
      sccb.siod_oe <= 1'b0;
      qcnt         <= '0;
      q            <= '0;
      bitcnt       <= '0;
      shreg        <= '0;
      dcnt         <= '0;
`ifdef SCCB_ACK_CHECK_EN
      nack         <= 1'b0;
      retries      <= '0;
      err          <= 1'b0;
`endif
    end else begin
      // Free-running quarter timer; every state entry below restarts it.
      if (qtick) begin
        qcnt <= '0;
        q    <= q + 2'd1;
      end else begin
        qcnt <= qcnt + QW'(1);
      end

      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= FETCH;
            rom_addr   <= '0;
            busy       <= 1'b1;
            setup_done <= 1'b0;
            qcnt       <= '0;
            q          <= '0;
`ifdef SCCB_ACK_CHECK_EN
            err        <= 1'b0;
            nack       <= 1'b0;
            retries    <= '0;
`endif
          end
        end

        FETCH: begin
          state <= DECODE;
          qcnt  <= '0;
          q     <= '0;
        end

        DECODE: begin
          qcnt <= '0;
          q    <= '0;
          if (rom_data == 16'hFFFF) begin
            state      <= DONE;
            busy       <= 1'b0;
            setup_done <= 1'b1;
          end else if (rom_data == 16'hFFF0) begin
            state <= DELAY;
            dcnt  <= '0;
          end else begin
            state  <= START;
            shreg  <= {DEV_ADDR, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
            bitcnt <= '0;
          end
        end

        START: begin
          if (qtick && q == 2'd3) begin
            state  <= BITS;
            bitcnt <= '0;
            qcnt   <= '0;
            q      <= '0;
          end
        end

        BITS: begin
          if (qtick) begin
`ifdef SCCB_ACK_CHECK_EN
            if (q == 2'd2 && ack_slot && sccb.siod_in)
              nack <= 1'b1;
            // nack can only be set on a 9th bit, so seeing it at q3
            // means the byte just completed and the write is abandoned.
            if (q == 2'd3 && (bitcnt == 5'd26 || nack)) begin
`else
            if (q == 2'd3 && bitcnt == 5'd26) begin
`endif
              state <= STOP;
              qcnt  <= '0;
              q     <= '0;
            end else if (q == 2'd3) begin
              bitcnt <= bitcnt + 5'd1;
              shreg  <= {shreg[25:0], 1'b0};
            end
          end
        end

        STOP: begin
          if (qtick && q == 2'd3) begin
            state <= GAP;
            qcnt  <= '0;
            q     <= '0;
          end
        end

        GAP: begin
          if (qtick && q == 2'd3) begin
            qcnt <= '0;
            q    <= '0;
`ifdef SCCB_ACK_CHECK_EN
            if (nack) begin
              nack <= 1'b0;
              if (retries == 2'd3) begin
                err        <= 1'b1;
                state      <= DONE;
                busy       <= 1'b0;
                setup_done <= 1'b1;
              end else begin
                retries <= retries + 2'd1;
                state   <= FETCH;  // same rom_addr: retry the entry
              end
            end else
`endif
            if (rom_addr == 8'hFF) begin
              state      <= DONE;
              busy       <= 1'b0;
              setup_done <= 1'b1;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= FETCH;
`ifdef SCCB_ACK_CHECK_EN
              retries  <= '0;
`endif
            end
          end
        end

        DELAY: begin
          if (dcnt == DW'(DLY_LAST)) begin
            qcnt <= '0;
            q    <= '0;
            if (rom_addr == 8'hFF) begin
              state      <= DONE;
              busy       <= 1'b0;
              setup_done <= 1'b1;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= FETCH;
`ifdef SCCB_ACK_CHECK_EN
              retries  <= '0;
`endif
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Bus pins are registered from the current state/quarter, so they lag
      // the sequencer by one cycle uniformly; quarter lengths are unaffected.
      unique case (state)
        START: begin
          sccb.sioc    <= (q < 2'd2);
          sccb.siod_oe <= (q != 2'd0);
        end
        BITS: begin
          sccb.sioc    <= (q == 2'd1) || (q == 2'd2);
          sccb.siod_oe <= ~shreg[26];
        end
        STOP: begin
          sccb.sioc    <= (q != 2'd0);
          sccb.siod_oe <= (q < 2'd2);
        end
        default: begin
          sccb.sioc    <= 1'b1;
          sccb.siod_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// ---------------------------------------------------------------------------
// tb_ov7670_sccb_config
//   Bench for ov7670_sccb_config. Runs at 4 MHz / 100 kHz so that QDIV = 10
//   (SIOC period 40 cycles) and a 1 ms delay entry is 4000 cycles. Expected
//   SCCB writes are queued when a run is started; an SCCB decoder on the bus
//   pops and compares each completed write. A slave model ACKs every 9th bit
//   unless ack_en is cleared.
// ---------------------------------------------------------------------------
module tb_ov7670_sccb_config;

  localparam int unsigned CLK_HZ    = 4_000_000;
  localparam int unsigned SCCB_HZ   = 100_000;
  localparam int unsigned DMS       = 1;
  localparam int          QDIV      = 10;    // 4e6 / (4 * 1e5)
  localparam int          DELAY_CYC = 4000;  // 4e6 / 1000 * 1

  typedef struct {
    int          nbytes;
    logic [23:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy;
  logic        setup_done;
  logic        err;
  logic        pull = 1'b0;
  logic        sda_line;
  bit          ack_en = 1'b1;

  logic [15:0] rom [256];

  int n_checks = 0;
  int n_pass   = 0;

  txn_t exp_q[$];
  int   idle_q[$];

  ov7670_sccb_config_if bus ();

  assign sda_line    = ~(bus.siod_oe | pull);
  assign bus.siod_in = sda_line;

  ov7670_sccb_config #(
    .CLK_FREQ_HZ (CLK_HZ),
    .SCCB_FREQ_HZ(SCCB_HZ),
    .DEV_ADDR    (8'h42),
    .DELAY_MS    (DMS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .sccb      (bus),
    .busy      (busy),
    .setup_done(setup_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- SCCB decoder / scoreboard monitor ----------------
  logic        psioc = 1'b1;
  logic        psda  = 1'b1;
  logic        cs, cd, pend;
  bit          in_txn = 1'b0;
  bit          pend_v = 1'b0;
  int          dec_bits = 0;
  logic [23:0] dat = '0;
  int          since_sioc = 1000;
  int          since_ss   = 1000;
  int          sioc_edges = 0;
  int          viol       = 0;
  int          txn_count  = 0;
  int          ncyc       = 0;
  int          last_rise  = -1;
  int          last_stop  = 0;
  txn_t        got;

  always @(negedge clk) begin
    ncyc++;
    if (!reset) begin
      in_txn     = 1'b0;
      pend_v     = 1'b0;
      pull       = 1'b0;
      psioc      = 1'b1;
      psda       = 1'b1;
      last_rise  = -1;
      since_sioc = 1000;
      since_ss   = 1000;
    end else begin
      cs = bus.sioc;
      cd = sda_line;
      since_sioc++;
      since_ss++;
      if (cs != psioc) begin
        sioc_edges++;
        if (since_ss < QDIV || cd != psda) begin
          viol++;
          $display("timing violation: SIOC edge at cycle %0d", ncyc);
        end
        since_sioc = 0;
        if (in_txn) begin
          if (cs) begin
            if (last_rise >= 0 && ncyc - last_rise != 4 * QDIV) begin
              viol++;
              $display("timing violation: SIOC period %0d at cycle %0d", ncyc - last_rise, ncyc);
            end
            last_rise = ncyc;
            pend      = cd;
            pend_v    = 1'b1;
          end else begin
            // a bit counts once SIOC falls again; the stop's SIOC rise never does
            if (pend_v) begin
              if (dec_bits % 9 != 8) dat = {dat[22:0], pend};
              dec_bits++;
              pend_v = 1'b0;
            end
            pull = ack_en && (dec_bits % 9 == 8);
          end
        end
      end else if (cs && cd != psda) begin
        if (since_sioc < QDIV) begin
          viol++;
          $display("timing violation: start/stop too close to SIOC edge at cycle %0d", ncyc);
        end
        since_ss = 0;
        if (!cd && !in_txn) begin
          in_txn    = 1'b1;
          dec_bits  = 0;
          dat       = '0;
          pend_v    = 1'b0;
          last_rise = -1;
          idle_q.push_back(ncyc - last_stop);
        end else if (cd && in_txn) begin
          in_txn    = 1'b0;
          pull      = 1'b0;
          last_stop = ncyc;
          txn_count++;
          check("sb_txn_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check("sb_txn_bytes", dec_bits / 9, got.nbytes);
            check("sb_txn_data", dat, got.data);
          end
        end else begin
          viol++;
          $display("timing violation: SIOD moved while SIOC high at cycle %0d", ncyc);
        end
      end
      psioc = cs;
      psda  = cd;
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_basic();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1100;
    rom[3] = 16'hFFFF;
  endtask

  task automatic push_txn(input int nb, input logic [23:0] d);
    txn_t t;
    t.nbytes = nb;
    t.data   = d;
    exp_q.push_back(t);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!setup_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", setup_done, 1);
  endtask

  task automatic check_gap();
    int g = (idle_q.size() >= 2) ? idle_q[1] : 0;
    check("delay_gap_in_range", (g >= DELAY_CYC) && (g <= DELAY_CYC + 8 * QDIV + 8), 1);
  endtask

  initial begin
    int n, bcnt, e0;
    reset = 1'b0;
    start = 1'b0;
    load_basic();
    repeat (3) @(negedge clk);
    check("rst_sioc", bus.sioc, 1);
    check("rst_siod_oe", bus.siod_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_setup_done", setup_done, 0);
    check("rst_err", err, 0);
    check("rst_rom_addr", rom_addr, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // basic table, with an ignored start while busy
    push_txn(3, 24'h421280);
    push_txn(3, 24'h421100);
    idle_q.delete();
    pulse_start();
    repeat (300) @(negedge clk);
    check("busy_mid_run", busy, 1);
    pulse_start();
    wait_done(30000);
    check("basic_busy_low", busy, 0);
    check("basic_rom_addr", rom_addr, 3);
    check("basic_err", err, 0);
    check("basic_txn_count", txn_count, 2);
    check("basic_sb_empty", exp_q.size(), 0);
    check_gap();

    // restart after DONE repeats identically
    push_txn(3, 24'h421280);
    push_txn(3, 24'h421100);
    idle_q.delete();
    pulse_start();
    check("restart_done_low", setup_done, 0);
    check("restart_busy", busy, 1);
    wait_done(30000);
    check("restart_rom_addr", rom_addr, 3);
    check("restart_txn_count", txn_count, 4);
    check("restart_sb_empty", exp_q.size(), 0);
    check_gap();

    // empty table
    rom[0] = 16'hFFFF;
    e0 = sioc_edges;
    pulse_start();
    n = 1;
    bcnt = 0;
    while (!setup_done && n < 50) begin
      if (busy) bcnt++;
      @(negedge clk);
      n++;
    end
    check("empty_latency_le4", n <= 4, 1);
    check("empty_busy_pulse", (bcnt >= 1) && (bcnt <= 4), 1);
    check("empty_busy_low", busy, 0);
    check("empty_no_sioc_edge", sioc_edges, e0);
    check("empty_rom_addr", rom_addr, 0);
    rom[0] = 16'h1280;

    // reset in the middle of a byte
    pulse_start();
    n = 0;
    while (dec_bits < 4 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reached_bits", dec_bits >= 4, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midrst_sioc", bus.sioc, 1);
    check("midrst_siod_oe", bus.siod_oe, 0);
    check("midrst_busy", busy, 0);
    e0 = sioc_edges;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2000) @(negedge clk);
    check("postrst_no_sioc_edge", sioc_edges, e0);
    check("postrst_busy", busy, 0);
    check("postrst_setup_done", setup_done, 0);
    check("postrst_txn_count", txn_count, 4);

`ifdef SCCB_ACK_CHECK_EN
    // slave never ACKs: entry 0 tried 4 times, address byte only
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) push_txn(1, 24'h000042);
    pulse_start();
    wait_done(30000);
    check("nack_err", err, 1);
    check("nack_busy_low", busy, 0);
    check("nack_rom_addr", rom_addr, 0);
    check("nack_txn_count", txn_count, 8);
    check("nack_sb_empty", exp_q.size(), 0);
    ack_en = 1'b1;
`endif

    check("timing_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
